// File: rtl/writeback_stage_pkg.sv
// Shared writeback constants and types, also used by the decode and bypass logic.
// Holds the multdiv exception-to-$rstatus mapping so every consumer agrees on it.
package writeback_stage_pkg;

  localparam int REG_W       = 5;
  localparam int DATA_W      = 32;
  localparam int REG_RSTATUS = 30;
  localparam int STATUS_MUL  = 4;
  localparam int STATUS_DIV  = 5;

  typedef logic [REG_W-1:0]  reg_idx_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef struct packed {
    reg_idx_t rd;
    data_t    data;
  } wb_entry_t;

  // An exception redirects the result to the status register with a status code.
  function automatic wb_entry_t md_effective(
    input reg_idx_t rd,
    input data_t    result,
    input logic     exception,
    input logic     is_div,
    input reg_idx_t status_reg,
    input data_t    status_mul,
    input data_t    status_div
  );
    wb_entry_t e;
    e.rd   = exception ? status_reg : rd;
    e.data = exception ? (is_div ? status_div : status_mul) : result;
    return e;
  endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// Pipeline/multdiv request side and regfile write side of the writeback stage.
// The stage uses the slave modport; the driving environment uses master.
interface writeback_stage_if;
  import writeback_stage_pkg::*;

  logic     mw_valid;
  logic     mw_writes_rd;
  logic     mw_is_load;
  reg_idx_t mw_rd;
  data_t    mw_result;
  data_t    mw_mem_data;

  logic     md_valid;
  logic     md_ready;
  reg_idx_t md_rd;
  data_t    md_result;
  logic     md_exception;
  logic     md_is_div;

  logic     ctrl_writeEnable;
  reg_idx_t ctrl_writeReg;
  data_t    data_writeReg;
  logic     md_dropped;
  data_t    wb_count;

  modport master (
    output mw_valid, mw_writes_rd, mw_is_load, mw_rd, mw_result, mw_mem_data,
    output md_valid, md_rd, md_result, md_exception, md_is_div,
    input  md_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg, md_dropped, wb_count
  );

  modport slave (
    input  mw_valid, mw_writes_rd, mw_is_load, mw_rd, mw_result, mw_mem_data,
    input  md_valid, md_rd, md_result, md_exception, md_is_div,
    output md_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg, md_dropped, wb_count
  );

endinterface

// File: rtl/wb_hold_buffer.sv
// One-entry holding slot for a multdiv result that lost arbitration; drains when no pipeline write.
// Latency 1 cycle from load; a pipeline write to the same rd kills the entry (drop_o, combinational).
module wb_hold_buffer
  import writeback_stage_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      load_i,
  input  wb_entry_t load_entry_i,
  input  logic      p_vld_i,
  input  reg_idx_t  p_rd_i,
  output logic      vld_o,
  output wb_entry_t entry_o,
  output logic      drop_o
);

  logic      vld_q, vld_d;
  wb_entry_t entry_q, entry_d;
  logic      drain;

  assign drop_o = vld_q & p_vld_i & (entry_q.rd == p_rd_i);
  assign drain  = vld_q & ~p_vld_i;

  // load_i is only ever raised while empty, so it never races a drain or drop.
  always_comb begin
    vld_d   = vld_q;
    entry_d = entry_q;
    if (load_i) begin
      vld_d   = 1'b1;
      entry_d = load_entry_i;
    end else if (drain || drop_o) begin
      vld_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q   <= 1'b0;
      entry_q <= '0;
    end else begin
      vld_q   <= vld_d;
      entry_q <= entry_d;
    end
  end

  assign vld_o   = vld_q;
  assign entry_o = entry_q;

endmodule

// File: rtl/writeback_stage.sv
// Regfile write-port owner: pipeline write > held multdiv entry > fresh multdiv entry, 1-cycle registered.
// Pipeline is never stalled; multdiv is backpressured (md_ready=0) only while the hold slot is full.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int RSTATUS_REG = REG_RSTATUS,
  parameter int STATUS_MUL  = writeback_stage_pkg::STATUS_MUL,
  parameter int STATUS_DIV  = writeback_stage_pkg::STATUS_DIV
)(
  input  logic               clock,
  input  logic               ctrl_reset_n,
  writeback_stage_if.slave   wb
);

  logic      p_req;
  data_t     p_data;
  logic      md_xfer;
  logic      md_live;
  logic      md_waw;
  logic      buf_load;
  wb_entry_t md_eff;
  logic      buf_vld;
  wb_entry_t buf_entry;
  logic      buf_drop;

  logic      we_q, we_d;
  reg_idx_t  waddr_q, waddr_d;
  data_t     wdata_q, wdata_d;
  logic      dropped_q, dropped_d;
  data_t     count_q, count_d;

  assign p_req  = wb.mw_valid & wb.mw_writes_rd & (wb.mw_rd != '0);
  assign p_data = wb.mw_is_load ? wb.mw_mem_data : wb.mw_result;

  assign wb.md_ready = ~buf_vld;
  assign md_xfer     = wb.md_valid & ~buf_vld;

  assign md_eff = md_effective(wb.md_rd, wb.md_result, wb.md_exception, wb.md_is_div,
                               reg_idx_t'(RSTATUS_REG), data_t'(STATUS_MUL), data_t'(STATUS_DIV));

  // A transfer to r0 completes the handshake but carries nothing to write.
  assign md_live  = md_xfer & (md_eff.rd != '0);
  assign md_waw   = md_live & p_req & (md_eff.rd == wb.mw_rd);
  assign buf_load = md_live & p_req & ~md_waw;

  wb_hold_buffer u_hold (
    .clk_i        (clock),
    .rst_ni       (ctrl_reset_n),
    .load_i       (buf_load),
    .load_entry_i (md_eff),
    .p_vld_i      (p_req),
    .p_rd_i       (wb.mw_rd),
    .vld_o        (buf_vld),
    .entry_o      (buf_entry),
    .drop_o       (buf_drop)
  );

  always_comb begin
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (p_req) begin
      we_d    = 1'b1;
      waddr_d = wb.mw_rd;
      wdata_d = p_data;
    end else if (buf_vld) begin
      we_d    = 1'b1;
      waddr_d = buf_entry.rd;
      wdata_d = buf_entry.data;
    end else if (md_live) begin
      we_d    = 1'b1;
      waddr_d = md_eff.rd;
      wdata_d = md_eff.data;
    end
  end

  assign dropped_d = md_waw | buf_drop;
  assign count_d   = (we_d && (count_q != '1)) ? count_q + 32'd1 : count_q;

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      dropped_q <= 1'b0;
      count_q   <= '0;
    end else begin
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      dropped_q <= dropped_d;
      count_q   <= count_d;
    end
  end

  assign wb.ctrl_writeEnable = we_q;
  assign wb.ctrl_writeReg    = waddr_q;
  assign wb.data_writeReg    = wdata_q;
  assign wb.md_dropped       = dropped_q;
  assign wb.wb_count         = count_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed plus random bench for writeback_stage against a queue-based model of pending multdiv writes.
module tb_writeback_stage;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic clock;
  logic ctrl_reset_n;

  writeback_stage_if bus();

  writeback_stage dut (
    .clock        (clock),
    .ctrl_reset_n (ctrl_reset_n),
    .wb           (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  ent_t        pend[$];
  logic        exp_we;
  logic [4:0]  exp_rd;
  logic [31:0] exp_data;
  logic        exp_drop;
  logic [31:0] exp_count;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive_p(input logic v, input logic wr, input logic ld, input logic [4:0] rd,
                         input logic [31:0] res, input logic [31:0] mem);
    bus.mw_valid     = v;
    bus.mw_writes_rd = wr;
    bus.mw_is_load   = ld;
    bus.mw_rd        = rd;
    bus.mw_result    = res;
    bus.mw_mem_data  = mem;
  endtask

  task automatic drive_md(input logic v, input logic [4:0] rd, input logic [31:0] res,
                          input logic exc, input logic div);
    bus.md_valid     = v;
    bus.md_rd        = rd;
    bus.md_result    = res;
    bus.md_exception = exc;
    bus.md_is_div    = div;
  endtask

  task automatic idle();
    drive_p(0, 0, 0, 5'd0, 32'd0, 32'd0);
    drive_md(0, 5'd0, 32'd0, 0, 0);
  endtask

  task automatic model_reset();
    pend.delete();
    exp_we    = 0;
    exp_rd    = 0;
    exp_data  = 0;
    exp_drop  = 0;
    exp_count = 0;
  endtask

  task automatic check_outputs(input string phase);
    check({phase, ".we"},       {31'd0, bus.ctrl_writeEnable}, {31'd0, exp_we});
    check({phase, ".rd"},       {27'd0, bus.ctrl_writeReg},    {27'd0, exp_rd});
    check({phase, ".data"},     bus.data_writeReg,             exp_data);
    check({phase, ".dropped"},  {31'd0, bus.md_dropped},       {31'd0, exp_drop});
    check({phase, ".count"},    bus.wb_count,                  exp_count);
    check({phase, ".md_ready"}, {31'd0, bus.md_ready},         (pend.size() == 0) ? 32'd1 : 32'd0);
  endtask

  // Applies the currently driven inputs to the model, clocks once, compares on the falling edge.
  task automatic step(input string phase);
    logic        p, xfer;
    logic [4:0]  erd;
    logic [31:0] edat, pdat;
    ent_t        e;
    p    = bus.mw_valid && bus.mw_writes_rd && (bus.mw_rd != 0);
    pdat = bus.mw_is_load ? bus.mw_mem_data : bus.mw_result;
    xfer = bus.md_valid && (pend.size() == 0);
    erd  = bus.md_exception ? 5'd30 : bus.md_rd;
    edat = bus.md_exception ? (bus.md_is_div ? 32'd5 : 32'd4) : bus.md_result;
    exp_we   = 0;
    exp_drop = 0;
    if (p) begin
      exp_we   = 1;
      exp_rd   = bus.mw_rd;
      exp_data = pdat;
      if (pend.size() != 0 && pend[0].rd == bus.mw_rd) begin
        pend.delete(0);
        exp_drop = 1;
      end
      if (xfer && erd == bus.mw_rd) exp_drop = 1;
      else if (xfer && erd != 0) begin
        e.rd = erd; e.data = edat;
        pend.push_back(e);
      end
    end else if (pend.size() != 0) begin
      e = pend.pop_front();
      exp_we = 1; exp_rd = e.rd; exp_data = e.data;
    end else if (xfer && erd != 0) begin
      exp_we = 1; exp_rd = erd; exp_data = edat;
    end
    if (exp_we && exp_count != 32'hFFFF_FFFF) exp_count = exp_count + 1;
    @(posedge clock);
    @(negedge clock);
    check_outputs(phase);
  endtask

  task automatic async_reset_check(input string phase);
    idle();
    #2 ctrl_reset_n = 0;
    #1;
    check({phase, ".rst_we"},    {31'd0, bus.ctrl_writeEnable}, 32'd0);
    check({phase, ".rst_rd"},    {27'd0, bus.ctrl_writeReg},    32'd0);
    check({phase, ".rst_data"},  bus.data_writeReg,             32'd0);
    check({phase, ".rst_drop"},  {31'd0, bus.md_dropped},       32'd0);
    check({phase, ".rst_count"}, bus.wb_count,                  32'd0);
    check({phase, ".rst_ready"}, {31'd0, bus.md_ready},         32'd1);
    model_reset();
    @(negedge clock);
    ctrl_reset_n = 1;
  endtask

  initial begin
    ctrl_reset_n = 0;
    idle();
    model_reset();
    repeat (2) @(negedge clock);
    check_outputs("reset");
    ctrl_reset_n = 1;

    // Load data selected over ALU result
    drive_p(1, 1, 1, 5'd5, 32'h1, 32'hDEADBEEF);
    step("load");
    check("load.data_const", bus.data_writeReg, 32'hDEADBEEF);
    check("load.count_const", bus.wb_count, 32'd1);

    // r0 is never written, from either source
    drive_p(1, 1, 0, 5'd0, 32'h1234, 32'h0);
    step("r0_pipe");
    check("r0_pipe.we_const", {31'd0, bus.ctrl_writeEnable}, 32'd0);
    idle();
    drive_md(1, 5'd0, 32'h77, 0, 0);
    step("r0_md");
    check("r0_md.count_const", bus.wb_count, 32'd1);

    // Conflict: multdiv loses to pipeline, drains next idle cycle
    drive_p(1, 1, 0, 5'd3, 32'h11, 32'h0);
    drive_md(1, 5'd7, 32'h22, 0, 0);
    step("conflict1");
    check("conflict1.ready_const", {31'd0, bus.md_ready}, 32'd0);
    idle();
    step("conflict2");
    check("conflict2.rd_const", {27'd0, bus.ctrl_writeReg}, 32'd7);
    check("conflict2.data_const", bus.data_writeReg, 32'h22);

    // WAW: buffered r9 killed by younger pipeline write to r9
    drive_p(1, 1, 0, 5'd2, 32'hA, 32'h0);
    drive_md(1, 5'd9, 32'h99, 0, 0);
    step("waw_fill");
    idle();
    drive_p(1, 1, 0, 5'd9, 32'h5, 32'h0);
    step("waw_hit");
    check("waw_hit.drop_const", {31'd0, bus.md_dropped}, 32'd1);
    idle();
    step("waw_after");
    check("waw_after.we_const", {31'd0, bus.ctrl_writeEnable}, 32'd0);
    step("waw_after2");

    // WAW against a same-cycle transfer
    drive_p(1, 1, 0, 5'd12, 32'h66, 32'h0);
    drive_md(1, 5'd12, 32'h67, 0, 1);
    step("waw_xfer");
    idle();
    step("waw_xfer_after");

    // Exceptions redirect to $rstatus
    drive_md(1, 5'd4, 32'hFFFF, 1, 1);
    step("exc_div");
    check("exc_div.rd_const", {27'd0, bus.ctrl_writeReg}, 32'd30);
    check("exc_div.data_const", bus.data_writeReg, 32'd5);
    drive_md(1, 5'd4, 32'hFFFF, 1, 0);
    step("exc_mul");
    check("exc_mul.data_const", bus.data_writeReg, 32'd4);
    idle();
    step("exc_idle");

    // Async reset while the hold slot is full
    drive_p(1, 1, 0, 5'd2, 32'h3, 32'h0);
    drive_md(1, 5'd11, 32'h44, 0, 0);
    step("rst_fill");
    async_reset_check("rst_mid");
    repeat (3) step("rst_post");

    // Random traffic with small rd range to provoke collisions
    for (int i = 0; i < 3000; i++) begin
      int busy;
      busy = (i / 200) % 3;
      drive_p($urandom_range(0, 3) < busy + 1, $urandom_range(0, 3) != 0, 1'($urandom),
              5'($urandom_range(0, 7)), $urandom, $urandom);
      drive_md($urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom,
               $urandom_range(0, 7) == 0, 1'($urandom));
      step("rand");
      if (i == 1500) async_reset_check("rand_rst");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
